// File: rtl/pipe_kogge_stone_sub_pkg.sv
// Shared constants, types and helpers for the pipelined Kogge-Stone subtractor.
`timescale 1ns/1ps

package ks_pkg;

  localparam int KS_BW  = 32;
  localparam int KS_HBW = KS_BW / 2;

  // One prefix-network node: group generate and group propagate.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of black/grey cell levels needed to span a width.
  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/pipe_kogge_stone_sub_if.sv
// Operand/result handshake bundle for pipe_kogge_stone_sub.
// Flag signals exist only when KS_SUB_FLAGS_EN is defined.
`timescale 1ns/1ps

interface pipe_kogge_stone_sub_if #(
  parameter int BW = 32
);

  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] A;
  logic [BW-1:0] B;
  logic          bin;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] diff;
  logic          bout;
`ifdef KS_SUB_FLAGS_EN
  logic          zero;
  logic          neg;
  logic          ovf;
`endif

  modport master (
    output in_valid, A, B, bin, out_ready,
    input  in_ready, out_valid, diff, bout
`ifdef KS_SUB_FLAGS_EN
    , input zero, neg, ovf
`endif
  );

  modport slave (
    input  in_valid, A, B, bin, out_ready,
    output in_ready, out_valid, diff, bout
`ifdef KS_SUB_FLAGS_EN
    , output zero, neg, ovf
`endif
  );

endinterface

// File: rtl/pipe_kogge_stone_sub_prefix.sv
// Combinational Kogge-Stone carry network: carry into every bit plus carry-out.
`timescale 1ns/1ps

module ks_prefix_add
  import ks_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] g,
  input  logic [W-1:0] p,
  input  logic         cin,
  output logic [W-1:0] carry,
  output logic         cout
);

  localparam int LVLS = ks_levels(W);

  logic [W-1:0] w_g_lvl;
  logic [W-1:0] w_p_lvl;
  logic [W-1:0] w_g_nxt;
  logic [W-1:0] w_p_nxt;

  always_comb begin
    // NOTE: every variable written here gets a full default first, so no path
    // leaves a bit unassigned and no latch can be inferred.
    w_g_lvl    = g;
    w_p_lvl    = p;
    w_g_nxt    = '0;
    w_p_nxt    = '0;
    // Fold carry-in into bit 0 so each prefix group [i:0] already includes it.
    w_g_lvl[0] = g[0] | (p[0] & cin);
    for (int lv = 0; lv < LVLS; lv++) begin
      // Positions below the span distance pass through as buffers.
      w_g_nxt = w_g_lvl;
      w_p_nxt = w_p_lvl;
      for (int i = (1 << lv); i < W; i++) begin
        w_g_nxt[i] = w_g_lvl[i] | (w_p_lvl[i] & w_g_lvl[i - (1 << lv)]);
        w_p_nxt[i] = w_p_lvl[i] & w_p_lvl[i - (1 << lv)];
      end
      w_g_lvl = w_g_nxt;
      w_p_lvl = w_p_nxt;
    end
  end

  assign carry = {w_g_lvl[W-2:0], cin};
  assign cout  = w_g_lvl[W-1];

endmodule

// File: rtl/pipe_kogge_stone_sub.sv
// Two-stage pipelined A - B - bin subtractor with Kogge-Stone borrow prefix and
// valid/ready back-pressure. Optional zero/neg/ovf flags under KS_SUB_FLAGS_EN.
`timescale 1ns/1ps

module pipe_kogge_stone_sub
  import ks_pkg::*;
#(
  parameter int BW  = KS_BW,
  parameter int HBW = BW / 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  pipe_kogge_stone_sub_if.slave    bus
);

  localparam int HW = BW - HBW;

  // Subtraction as A + ~B + ~bin: generate/propagate on the inverted subtrahend.
  logic [BW-1:0]  w_g;
  logic [BW-1:0]  w_p;
  logic [HBW-1:0] w_c_lo;
  logic           w_cout_lo;
  logic [HBW-1:0] w_diff_lo;
  gp_t  [HW-1:0]  w_gp_hi;

  logic           w_adv1;
  logic           w_adv2;
  logic           w_accept;

  logic           r_v1;
  logic [HBW-1:0] r_diff_lo;
  logic           r_c1;
  gp_t  [HW-1:0]  r_gp_hi;

  logic [HW-1:0]  w_g_hi;
  logic [HW-1:0]  w_p_hi;
  logic [HW-1:0]  w_c_hi;
  logic           w_cout_hi;
  logic [HW-1:0]  w_diff_hi;

  logic           r_v2;
  logic [BW-1:0]  r_diff;
  logic           r_bout;

`ifdef KS_SUB_FLAGS_EN
  logic           r_sx1;
  logic           r_am1;
  logic           r_zero;
  logic           r_neg;
  logic           r_ovf;
  logic [BW-1:0]  w_diff_full;
`endif

  assign w_g = bus.A & ~bus.B;
  assign w_p = bus.A ^ ~bus.B;

  ks_prefix_add #(.W(HBW)) u_prefix_lo (
    .g     (w_g[HBW-1:0]),
    .p     (w_p[HBW-1:0]),
    .cin   (~bus.bin),
    .carry (w_c_lo),
    .cout  (w_cout_lo)
  );

  assign w_diff_lo = w_p[HBW-1:0] ^ w_c_lo;

  always_comb begin
    w_gp_hi = '0;
    w_g_hi  = '0;
    w_p_hi  = '0;
    for (int i = 0; i < HW; i++) begin
      w_gp_hi[i].g = w_g[HBW + i];
      w_gp_hi[i].p = w_p[HBW + i];
      w_g_hi[i]    = r_gp_hi[i].g;
      w_p_hi[i]    = r_gp_hi[i].p;
    end
  end

  ks_prefix_add #(.W(HW)) u_prefix_hi (
    .g     (w_g_hi),
    .p     (w_p_hi),
    .cin   (r_c1),
    .carry (w_c_hi),
    .cout  (w_cout_hi)
  );

  assign w_diff_hi = w_p_hi ^ w_c_hi;

  // Stage 2 drains when empty or consumed; stage 1 follows it. out_ready
  // reaches in_ready combinationally so a full pipe can still accept.
  assign w_adv2   = !r_v2 || bus.out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign w_accept = bus.in_valid && w_adv1;

  assign bus.in_ready = w_adv1;

  // NOTE: state is written with non-blocking assignments so both stages
  // sample the pre-edge values and shift together without ordering races.
  // NOTE: datapath registers are reset as well because diff/bout must read
  // zero straight out of reset, not only after the first result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v1      <= 1'b0;
      r_diff_lo <= '0;
      r_c1      <= 1'b0;
      r_gp_hi   <= '0;
`ifdef KS_SUB_FLAGS_EN
      r_sx1     <= 1'b0;
      r_am1     <= 1'b0;
`endif
    end else if (w_adv1) begin
      r_v1 <= bus.in_valid;
      if (w_accept) begin
        r_diff_lo <= w_diff_lo;
        r_c1      <= w_cout_lo;
        r_gp_hi   <= w_gp_hi;
`ifdef KS_SUB_FLAGS_EN
        r_sx1     <= bus.A[BW-1] ^ bus.B[BW-1];
        r_am1     <= bus.A[BW-1];
`endif
      end
    end
  end

`ifdef KS_SUB_FLAGS_EN
  assign w_diff_full = {w_diff_hi, r_diff_lo};
`endif

  // A bubble in stage 1 clears v2 but leaves the last result registers alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v2   <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
`ifdef KS_SUB_FLAGS_EN
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
`endif
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_diff <= {w_diff_hi, r_diff_lo};
        r_bout <= ~w_cout_hi;
`ifdef KS_SUB_FLAGS_EN
        r_zero <= (w_diff_full == '0);
        r_neg  <= w_diff_full[BW-1];
        r_ovf  <= r_sx1 & (r_am1 ^ w_diff_full[BW-1]);
`endif
      end
    end
  end

  assign bus.out_valid = r_v2;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
`ifdef KS_SUB_FLAGS_EN
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_pipe_kogge_stone_sub.sv
// Self-checking bench for pipe_kogge_stone_sub: directed table, stall/full-pipe
// sequences, random back-pressure stream and mid-stream reset, scoreboarded.
`timescale 1ns/1ps

module tb_pipe_kogge_stone_sub;

  localparam int BW  = 32;
  localparam int HBW = 16;

  typedef struct packed {
    logic [BW-1:0] diff;
    logic          bout;
    logic          zero;
    logic          neg;
    logic          ovf;
  } res_t;

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          bin;
    res_t          exp;
  } vec_t;

  logic clk;
  logic resetn;

  pipe_kogge_stone_sub_if #(.BW(BW)) bus ();

  pipe_kogge_stone_sub #(.BW(BW), .HBW(HBW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  res_t          sb[$];
  logic          stall_prev = 1'b0;
  logic [BW-1:0] held_diff  = '0;
  vec_t          tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic bi);
    logic [BW:0] t;
    res_t        r;
    t      = {1'b0, a} - {1'b0, b} - {{BW{1'b0}}, bi};
    r.diff = t[BW-1:0];
    r.bout = t[BW];
    r.zero = (t[BW-1:0] == '0);
    r.neg  = t[BW-1];
    r.ovf  = (a[BW-1] ^ b[BW-1]) & (a[BW-1] ^ t[BW-1]);
    return r;
  endfunction

  // One clock: drive at negedge, check handshake/outputs, then take the edge.
  task automatic step(input logic v, input logic [BW-1:0] a, input logic [BW-1:0] b,
                      input logic bi, input logic ordy, input res_t exp, output logic acc);
    res_t got;
    @(negedge clk);
    bus.in_valid  = v;
    bus.A         = a;
    bus.B         = b;
    bus.bin       = bi;
    bus.out_ready = ordy;
    #1;
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, !(sb.size() == 2 && !ordy)});
    if (stall_prev) begin
      check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
      check("stall_diff", {32'd0, bus.diff}, {32'd0, held_diff});
    end
    if (bus.out_valid && sb.size() == 0) begin
      check("spurious_out", 64'd1, 64'd0);
    end else if (bus.out_valid && ordy) begin
      got = sb.pop_front();
      check("diff", {32'd0, bus.diff}, {32'd0, got.diff});
      check("bout", {63'd0, bus.bout}, {63'd0, got.bout});
`ifdef KS_SUB_FLAGS_EN
      check("zero", {63'd0, bus.zero}, {63'd0, got.zero});
      check("neg",  {63'd0, bus.neg},  {63'd0, got.neg});
      check("ovf",  {63'd0, bus.ovf},  {63'd0, got.ovf});
`endif
    end
    stall_prev = bus.out_valid && !ordy;
    held_diff  = bus.diff;
    acc        = v && bus.in_ready;
    if (acc) sb.push_back(exp);
    @(posedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 40 && sb.size() != 0; k++)
      step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("drain_empty", sb.size(), 64'd0);
  endtask

  initial begin
    logic          acc;
    logic [BW-1:0] ra;
    logic [BW-1:0] rb;
    logic          rbi;
    int            n_acc;

    tbl[0] = '{a: 32'h0000_0005, b: 32'h0000_0003, bin: 1'b0,
               exp: '{diff: 32'h0000_0002, bout: 1'b0, zero: 1'b0, neg: 1'b0, ovf: 1'b0}};
    tbl[1] = '{a: 32'h0000_0000, b: 32'h0000_0001, bin: 1'b0,
               exp: '{diff: 32'hFFFF_FFFF, bout: 1'b1, zero: 1'b0, neg: 1'b1, ovf: 1'b0}};
    tbl[2] = '{a: 32'h8000_0000, b: 32'h0000_0001, bin: 1'b0,
               exp: '{diff: 32'h7FFF_FFFF, bout: 1'b0, zero: 1'b0, neg: 1'b0, ovf: 1'b1}};
    tbl[3] = '{a: 32'h0001_0000, b: 32'h0000_FFFF, bin: 1'b1,
               exp: '{diff: 32'h0000_0000, bout: 1'b0, zero: 1'b1, neg: 1'b0, ovf: 1'b0}};
    tbl[4] = '{a: 32'h1234_5678, b: 32'h1234_5678, bin: 1'b0,
               exp: '{diff: 32'h0000_0000, bout: 1'b0, zero: 1'b1, neg: 1'b0, ovf: 1'b0}};
    tbl[5] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, bin: 1'b1,
               exp: '{diff: 32'hFFFF_FFFE, bout: 1'b0, zero: 1'b0, neg: 1'b1, ovf: 1'b0}};
    tbl[6] = '{a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF, bin: 1'b0,
               exp: '{diff: 32'h8000_0000, bout: 1'b1, zero: 1'b0, neg: 1'b1, ovf: 1'b1}};
    tbl[7] = '{a: 32'h0000_0000, b: 32'h0000_0000, bin: 1'b1,
               exp: '{diff: 32'hFFFF_FFFF, bout: 1'b1, zero: 1'b0, neg: 1'b1, ovf: 1'b0}};

    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_diff", {32'd0, bus.diff}, 64'd0);
    check("rst_bout", {63'd0, bus.bout}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Latency: result visible after the second register stage.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.A         = tbl[0].a;
    bus.B         = tbl[0].b;
    bus.bin       = tbl[0].bin;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("lat_stage1", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("lat_stage2", {63'd0, bus.out_valid}, 64'd1);
    check("lat_diff", {32'd0, bus.diff}, {32'd0, tbl[0].exp.diff});
    @(posedge clk);

    // Directed table, back to back with out_ready high.
    for (int i = 0; i < 8; i++)
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].bin, 1'b1, tbl[i].exp, acc);
    drain();

    // Fill both stages, stall, then accept while full as the pipe shifts.
    step(1'b1, tbl[1].a, tbl[1].b, tbl[1].bin, 1'b0, tbl[1].exp, acc);
    step(1'b1, tbl[2].a, tbl[2].b, tbl[2].bin, 1'b0, tbl[2].exp, acc);
    step(1'b1, tbl[3].a, tbl[3].b, tbl[3].bin, 1'b0, tbl[3].exp, acc);
    check("full_stall_no_accept", {63'd0, acc}, 64'd0);
    step(1'b1, tbl[3].a, tbl[3].b, tbl[3].bin, 1'b1, tbl[3].exp, acc);
    check("full_shift_accept", {63'd0, acc}, 64'd1);
    drain();

    // Random stream with random back-pressure.
    n_acc = 0;
    for (int k = 0; k < 300 && n_acc < 16; k++) begin
      ra  = $urandom;
      rb  = $urandom;
      rbi = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), ra, rb, rbi, 1'($urandom_range(0, 1)),
           model(ra, rb, rbi), acc);
      if (acc) n_acc++;
    end
    check("random_accepted", n_acc, 64'd16);
    drain();

    // Mid-stream reset with a full, stalled pipe.
    step(1'b1, tbl[5].a, tbl[5].b, tbl[5].bin, 1'b0, tbl[5].exp, acc);
    step(1'b1, tbl[6].a, tbl[6].b, tbl[6].bin, 1'b0, tbl[6].exp, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("async_rst_diff", {32'd0, bus.diff}, 64'd0);
    check("async_rst_bout", {63'd0, bus.bout}, 64'd0);
    sb.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    step(1'b1, tbl[4].a, tbl[4].b, tbl[4].bin, 1'b1, tbl[4].exp, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
